// File: rtl/common_types_pkg.sv
// Shared trap/CSR definitions: CSR addresses, CSR op encoding, trap FSM states
// and cause codes. Used by the decoder, the exception unit and trap_csr_unit.
package common_types_pkg;

  // Machine-mode trap CSRs
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;

  // Counters (machine read/write) and their user read-only shadows
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    RET  = 2'd2
  } trap_state_t;

  localparam logic [30:0] CAUSE_ILLEGAL = 31'd2;
  localparam logic [30:0] CAUSE_MTI     = 31'd7;
  localparam logic [30:0] CAUSE_MEI     = 31'd11;

  // MPP is hardwired to machine mode
  localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;

  // Zicsr read/modify/write combine of the old value and the operand
  function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old_val,
                                            logic [31:0] operand);
    logic [31:0] res;
    case (op)
      CSR_RW:  res = operand;
      CSR_RS:  res = old_val | operand;
      CSR_RC:  res = old_val & ~operand;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with per-half write strobes. A write to one half
// replaces that half and blocks the carry into the other half for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [32:0] lo_sum;

  // Next value: increment with carry unless a half is being written
  always_comb begin
    lo_sum = {1'b0, lo_q} + {32'b0, inc};
    lo_d   = wr_lo ? wdata : lo_sum[31:0];
    if (wr_hi) begin
      hi_d = wdata;
    end else if (wr_lo) begin
      hi_d = hi_q;
    end else begin
      hi_d = hi_q + {31'b0, lo_sum[32]};
    end
  end

  // Counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign count = {hi_q, lo_q};

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode trap CSR block: latches trap state, redirects fetch on
// exception/mret, serves Zicsr accesses and raises level interrupt requests.
// Optional counters (mcycle/minstret and shadows) under `define ZICNTR_EN.
module trap_csr_unit
  import common_types_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic [31:0] exception_pc,
  input  logic [31:0] exception_cause,
  input  logic        interrupt,
  input  logic        mret,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        inst_retire,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic        trap_redirect,
  output logic [31:0] trap_target
);

  trap_state_t state_q, state_d;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_mtie_q, mie_mtie_d;
  logic        mie_meie_q, mie_meie_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic        trap_redirect_q, trap_redirect_d;
  logic [31:0] trap_target_q, trap_target_d;
  logic        irq_req_q, irq_req_d;
  logic [31:0] irq_cause_q, irq_cause_d;

  csr_op_t     op;
  logic [31:0] mstatus_rd, mie_rd, mip_rd;
  logic [31:0] read_val, write_val;
  logic        implemented, read_only, write_attempt, illegal, csr_we, in_run;
  logic        ext_qual, timer_qual;
  logic        unused_inputs;

  assign op         = csr_op_t'(csr_op);
  assign in_run     = (state_q == RUN);
  assign mstatus_rd = MSTATUS_MPP | {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign mie_rd     = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
  assign mip_rd     = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};

`ifdef ZICNTR_EN
  logic [63:0] mcycle, minstret;

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_we && (csr_addr == CSR_MCYCLE)),
    .wr_hi (csr_we && (csr_addr == CSR_MCYCLEH)),
    .wdata (write_val),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_retire),
    .wr_lo (csr_we && (csr_addr == CSR_MINSTRET)),
    .wr_hi (csr_we && (csr_addr == CSR_MINSTRETH)),
    .wdata (write_val),
    .count (minstret)
  );

  assign unused_inputs = ^{exception_cause[31], exception_pc[1:0]};
`else
  assign unused_inputs = ^{exception_cause[31], exception_pc[1:0], inst_retire};
`endif

  // Read mux; unknown addresses flag the access as unimplemented
  always_comb begin
    read_val    = '0;
    implemented = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  read_val = mstatus_rd;
      CSR_MIE:      read_val = mie_rd;
      CSR_MTVEC:    read_val = {mtvec_q, 2'b00};
      CSR_MSCRATCH: read_val = mscratch_q;
      CSR_MEPC:     read_val = {mepc_q, 2'b00};
      CSR_MCAUSE:   read_val = mcause_q;
      CSR_MTVAL:    read_val = mtval_q;
      CSR_MIP:      read_val = mip_rd;
`ifdef ZICNTR_EN
      CSR_MCYCLE,   CSR_CYCLE:    read_val = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   read_val = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  read_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: read_val = minstret[63:32];
`endif
      default:      implemented = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read and therefore legal on read-only CSRs
  assign read_only     = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MIP);
  assign write_attempt = (op == CSR_RW) ||
                         (((op == CSR_RS) || (op == CSR_RC)) && (csr_wdata != 32'b0));
  assign illegal       = csr_en && (!implemented || (read_only && write_attempt));
  assign csr_we        = csr_en && write_attempt && !illegal && in_run && !exception && !mret;
  assign write_val     = csr_apply(op, read_val, csr_wdata);

  assign csr_illegal   = illegal;
  assign csr_rdata     = (csr_en && !illegal) ? read_val : 32'b0;

  // CSR next state: exception > mret > CSR write, all blocked outside RUN
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mscratch_d     = mscratch_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (in_run) begin
      if (exception) begin
        mepc_d         = exception_pc[31:2];
        mcause_d       = {interrupt, exception_cause[30:0]};
        mtval_d        = '0;
        mstatus_mpie_d = mstatus_mie_q;
        mstatus_mie_d  = 1'b0;
      end else if (mret) begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_d  = write_val[3];
            mstatus_mpie_d = write_val[7];
          end
          CSR_MIE: begin
            mie_mtie_d = write_val[7];
            mie_meie_d = write_val[11];
          end
          CSR_MTVEC:    mtvec_d    = write_val[31:2];
          CSR_MSCRATCH: mscratch_d = write_val;
          CSR_MEPC:     mepc_d     = write_val[31:2];
          CSR_MCAUSE:   mcause_d   = write_val;
          CSR_MTVAL:    mtval_d    = write_val;
          default:      ;
        endcase
      end
    end
  end

  // CSR storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= RESET_MTVEC[31:2];
      mepc_q         <= '0;
      mscratch_q     <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mscratch_q     <= mscratch_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

  // Trap FSM next state and redirect outputs; TRAP/RET last exactly one cycle
  always_comb begin
    state_d         = state_q;
    trap_redirect_d = 1'b0;
    trap_target_d   = trap_target_q;
    case (state_q)
      RUN: begin
        if (exception) begin
          state_d         = TRAP;
          trap_redirect_d = 1'b1;
          trap_target_d   = {mtvec_q, 2'b00};
        end else if (mret) begin
          state_d         = RET;
          trap_redirect_d = 1'b1;
          trap_target_d   = {mepc_q, 2'b00};
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Interrupt request qualification; external wins over timer
  always_comb begin
    ext_qual    = irq_ext && mie_meie_q && mstatus_mie_q && in_run;
    timer_qual  = irq_timer && mie_mtie_q && mstatus_mie_q && in_run;
    irq_req_d   = ext_qual || timer_qual;
    irq_cause_d = '0;
    if (ext_qual) begin
      irq_cause_d = {1'b1, CAUSE_MEI};
    end else if (timer_qual) begin
      irq_cause_d = {1'b1, CAUSE_MTI};
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      trap_redirect_q <= 1'b0;
      trap_target_q   <= '0;
      irq_req_q       <= 1'b0;
      irq_cause_q     <= '0;
    end else begin
      state_q         <= state_d;
      trap_redirect_q <= trap_redirect_d;
      trap_target_q   <= trap_target_d;
      irq_req_q       <= irq_req_d;
      irq_cause_q     <= irq_cause_d;
    end
  end

  assign trap_redirect = trap_redirect_q;
  assign trap_target   = trap_target_q;
  assign irq_req       = irq_req_q;
  assign irq_cause     = irq_cause_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Self-checking bench for trap_csr_unit: directed table, hand-written trap,
// mret, interrupt and reset sequences, then randomized traffic against a model.
module tb_trap_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception, interrupt, mret, csr_en;
  logic [31:0] exception_pc, exception_cause, csr_wdata;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        irq_ext, irq_timer, inst_retire;
  logic        irq_req, trap_redirect;
  logic [31:0] irq_cause, trap_target;

  int checks = 0;
  int errors = 0;

  trap_csr_unit #(.RESET_MTVEC(32'h0000_8000)) dut (
    .clk             (clk),
    .rst             (rst),
    .exception       (exception),
    .exception_pc    (exception_pc),
    .exception_cause (exception_cause),
    .interrupt       (interrupt),
    .mret            (mret),
    .csr_en          (csr_en),
    .csr_op          (csr_op),
    .csr_addr        (csr_addr),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata),
    .csr_illegal     (csr_illegal),
    .irq_ext         (irq_ext),
    .irq_timer       (irq_timer),
    .inst_retire     (inst_retire),
    .irq_req         (irq_req),
    .irq_cause       (irq_cause),
    .trap_redirect   (trap_redirect),
    .trap_target     (trap_target)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic        m_flush, m_redirect, m_irq_req;
  logic [31:0] m_target, m_irq_cause;
`ifdef ZICNTR_EN
  logic [63:0] m_mcycle, m_minstret;
`endif

  task automatic m_reset();
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 32'h8000; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_flush = 0; m_redirect = 0; m_irq_req = 0; m_target = 0; m_irq_cause = 0;
`ifdef ZICNTR_EN
    m_mcycle = 0; m_minstret = 0;
`endif
  endtask

  task automatic m_lookup(input logic [11:0] a, output logic ok, output logic ro,
                          output logic [31:0] v);
    ok = 1'b1;
    v  = 0;
    case (a)
      12'h300: v = m_mstatus;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0);
`ifdef ZICNTR_EN
      12'hB00, 12'hC00: v = m_mcycle[31:0];
      12'hB80, 12'hC80: v = m_mcycle[63:32];
      12'hB02, 12'hC02: v = m_minstret[31:0];
      12'hB82, 12'hC82: v = m_minstret[63:32];
`endif
      default: ok = 1'b0;
    endcase
    ro = (a >= 12'hC00) || (a == 12'h344);
  endtask

  function automatic logic wr_attempt(input logic [1:0] o, input logic [31:0] w);
    return (o == 2'd1) || ((o != 2'd0) && (w != 0));
  endfunction

  task automatic m_read(output logic [31:0] v, output logic ill);
    logic ok, ro;
    logic [31:0] raw;
    m_lookup(csr_addr, ok, ro, raw);
    ill = csr_en && (!ok || (ro && wr_attempt(csr_op, csr_wdata)));
    v   = (csr_en && !ill) ? raw : 32'h0;
  endtask

  task automatic m_clock();
    logic ok, ro, ill, we, eq, tq;
    logic [31:0] old, nv;
    m_lookup(csr_addr, ok, ro, old);
    ill = !ok || (ro && wr_attempt(csr_op, csr_wdata));
    case (csr_op)
      2'd1:    nv = csr_wdata;
      2'd2:    nv = old | csr_wdata;
      default: nv = old & ~csr_wdata;
    endcase
    eq = irq_ext && m_mie[11] && m_mstatus[3] && !m_flush;
    tq = irq_timer && m_mie[7] && m_mstatus[3] && !m_flush;
    m_irq_req   = eq || tq;
    m_irq_cause = eq ? 32'h8000_000B : 32'h8000_0007;
    we = 1'b0;
    if (!m_flush && exception) begin
      m_target   = m_mtvec;
      m_redirect = 1'b1;
      m_flush    = 1'b1;
      m_mepc     = exception_pc & ~32'h3;
      m_mcause   = {interrupt, exception_cause[30:0]};
      m_mtval    = 0;
      m_mstatus  = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
    end else if (!m_flush && mret) begin
      m_target   = m_mepc;
      m_redirect = 1'b1;
      m_flush    = 1'b1;
      m_mstatus  = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else begin
      m_redirect = 1'b0;
      we         = !m_flush && csr_en && wr_attempt(csr_op, csr_wdata) && !ill;
      m_flush    = 1'b0;
    end
`ifdef ZICNTR_EN
    begin
      logic [63:0] cyc_n, ret_n;
      cyc_n = m_mcycle + 64'd1;
      ret_n = m_minstret + {63'b0, inst_retire};
      if (we && csr_addr == 12'hB00) cyc_n = {m_mcycle[63:32], nv};
      if (we && csr_addr == 12'hB80) cyc_n = {nv, m_mcycle[31:0] + 32'd1};
      if (we && csr_addr == 12'hB02) ret_n = {m_minstret[63:32], nv};
      if (we && csr_addr == 12'hB82) ret_n = {nv, m_minstret[31:0] + {31'b0, inst_retire}};
      m_mcycle   = cyc_n;
      m_minstret = ret_n;
    end
`endif
    if (we) begin
      case (csr_addr)
        12'h300: m_mstatus  = (nv & 32'h88) | 32'h1800;
        12'h304: m_mie      = nv & 32'h880;
        12'h305: m_mtvec    = nv & ~32'h3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~32'h3;
        12'h342: m_mcause   = nv;
        12'h343: m_mtval    = nv;
        default: ;
      endcase
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs applied; ends at the next posedge+1
  task automatic step();
    logic [31:0] er;
    logic        el;
    #2;
    m_read(er, el);
    chk("csr_rdata", csr_rdata, er);
    chk("csr_illegal", {31'b0, csr_illegal}, {31'b0, el});
    m_clock();
    @(posedge clk);
    #1;
    chk("trap_redirect", {31'b0, trap_redirect}, {31'b0, m_redirect});
    chk("trap_target", trap_target, m_target);
    chk("irq_req", {31'b0, irq_req}, {31'b0, m_irq_req});
    if (m_irq_req) chk("irq_cause", irq_cause, m_irq_cause);
  endtask

  task automatic idle();
    exception = 0; mret = 0; csr_en = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    interrupt = 0; inst_retire = 0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    idle();
    csr_en = 1; csr_op = 2'd0; csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] o, input logic [11:0] a, input logic [31:0] w,
                              input logic [31:0] r, input logic il);
    vec_t v;
    v.op = o; v.addr = a; v.wdata = w; v.exp_rdata = r; v.exp_ill = il;
    return v;
  endfunction

  logic [11:0] pool [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                             12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC82,
                             12'h123, 12'h300};

  initial begin
    idle();
    irq_ext = 0; irq_timer = 0; exception_pc = 0; exception_cause = 0;
    rst = 1'b1;
    #1;
    // Asynchronous reset values before any clock edge
    chk("reset trap_redirect", {31'b0, trap_redirect}, 32'h0);
    chk("reset trap_target", trap_target, 32'h0);
    chk("reset irq_req", {31'b0, irq_req}, 32'h0);
    chk("reset irq_cause", irq_cause, 32'h0);
    chk("reset csr_rdata", csr_rdata, 32'h0);
    do_reset();

    // Directed table, applied in order (writes feed later reads)
    vecs.push_back(mk(2'd0, 12'h305, 32'h0,         32'h0000_8000, 1'b0));
    vecs.push_back(mk(2'd0, 12'h300, 32'h0,         32'h0000_1800, 1'b0));
    vecs.push_back(mk(2'd1, 12'h340, 32'hDEAD_BEEF, 32'h0,         1'b0));
    vecs.push_back(mk(2'd0, 12'h340, 32'h0,         32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(2'd2, 12'h340, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(2'd3, 12'h340, 32'hDEAD_0000, 32'hDEAD_BEFF, 1'b0));
    vecs.push_back(mk(2'd0, 12'h340, 32'h0,         32'h0000_BEFF, 1'b0));
    vecs.push_back(mk(2'd1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0));
    vecs.push_back(mk(2'd0, 12'h300, 32'h0,         32'h0000_1888, 1'b0));
    vecs.push_back(mk(2'd1, 12'h300, 32'h0,         32'h0000_1888, 1'b0));
    vecs.push_back(mk(2'd1, 12'h305, 32'h0000_1003, 32'h0000_8000, 1'b0));
    vecs.push_back(mk(2'd0, 12'h305, 32'h0,         32'h0000_1000, 1'b0));
    vecs.push_back(mk(2'd1, 12'h305, 32'h0000_8000, 32'h0000_1000, 1'b0));
    vecs.push_back(mk(2'd1, 12'h344, 32'h0,         32'h0,         1'b1));
    vecs.push_back(mk(2'd2, 12'h344, 32'h0,         32'h0,         1'b0));
    vecs.push_back(mk(2'd1, 12'hC00, 32'h0,         32'h0,         1'b1));
    vecs.push_back(mk(2'd0, 12'h123, 32'h0,         32'h0,         1'b1));
    vecs.push_back(mk(2'd1, 12'h304, 32'hFFFF_FFFF, 32'h0,         1'b0));
    vecs.push_back(mk(2'd0, 12'h304, 32'h0,         32'h0000_0880, 1'b0));
    vecs.push_back(mk(2'd1, 12'h304, 32'h0,         32'h0000_0880, 1'b0));
    vecs.push_back(mk(2'd1, 12'h340, 32'h0,         32'h0000_BEFF, 1'b0));
    vecs.push_back(mk(2'd1, 12'h341, 32'h0000_0107, 32'h0,         1'b0));
    vecs.push_back(mk(2'd0, 12'h341, 32'h0,         32'h0000_0104, 1'b0));
`ifndef ZICNTR_EN
    vecs.push_back(mk(2'd0, 12'hB00, 32'h0,         32'h0,         1'b1));
    vecs.push_back(mk(2'd2, 12'hB80, 32'h0,         32'h0,         1'b1));
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      idle();
      csr_en = 1; csr_op = vecs[i].op; csr_addr = vecs[i].addr; csr_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d rdata", i), csr_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d illegal", i), {31'b0, csr_illegal}, {31'b0, vecs[i].exp_ill});
      step();
    end

    // Trap entry with MIE set
    idle(); csr_en = 1; csr_op = 2'd1; csr_addr = 12'h300; csr_wdata = 32'h8;
    step();
    idle(); exception = 1; exception_pc = 32'h124; exception_cause = 32'h2;
    step();
    chk("trap redirect", {31'b0, trap_redirect}, 32'h1);
    chk("trap target", trap_target, 32'h8000);
    idle(); mret = 1;  // ignored while in TRAP
    step();
    chk("trap pulse end", {31'b0, trap_redirect}, 32'h0);
    rd("mepc after trap", 12'h341, 32'h124);
    rd("mcause after trap", 12'h342, 32'h2);
    rd("mstatus after trap", 12'h300, 32'h1880);

    // mret back to mepc
    idle(); mret = 1;
    step();
    chk("mret redirect", {31'b0, trap_redirect}, 32'h1);
    chk("mret target", trap_target, 32'h124);
    idle();
    step();
    rd("mstatus after mret", 12'h300, 32'h1888);

    // Interrupt requests and priority
    idle(); csr_en = 1; csr_op = 2'd1; csr_addr = 12'h304; csr_wdata = 32'h880;
    step();
    idle(); irq_timer = 1; irq_ext = 1;
    step();
    chk("irq both req", {31'b0, irq_req}, 32'h1);
    chk("irq both cause", irq_cause, 32'h8000_000B);
    irq_ext = 0;
    step();
    chk("irq timer cause", irq_cause, 32'h8000_0007);
    irq_timer = 0;
    step();
    chk("irq dropped", {31'b0, irq_req}, 32'h0);

    // CSR write loses to a same-cycle exception
    idle(); csr_en = 1; csr_op = 2'd1; csr_addr = 12'h340; csr_wdata = 32'hAA;
    exception = 1; exception_pc = 32'h200; exception_cause = 32'h5;
    step();
    chk("exc beats csr redirect", {31'b0, trap_redirect}, 32'h1);
    idle(); csr_en = 1; csr_op = 2'd1; csr_addr = 12'h340; csr_wdata = 32'h55;
    step();
    rd("mscratch untouched", 12'h340, 32'h0);

`ifdef ZICNTR_EN
    idle(); csr_en = 1; csr_op = 2'd1; csr_addr = 12'hB00; csr_wdata = 32'hFFFF_FFFF;
    step();
    idle();
    step();
    rd("mcycleh after wrap", 12'hB80, 32'h1);
    rd("cycleh shadow", 12'hC80, 32'h1);
`else
    idle(); csr_en = 1; csr_op = 2'd0; csr_addr = 12'hB00;
    #1;
    chk("no counters illegal", {31'b0, csr_illegal}, 32'h1);
    step();
`endif

    // Reset in the middle of a trap drops the redirect
    idle(); exception = 1; exception_pc = 32'h300; exception_cause = 32'h3;
    step();
    rst = 1'b1;
    idle();
    #1;
    chk("midtrap reset redirect", {31'b0, trap_redirect}, 32'h0);
    chk("midtrap reset target", trap_target, 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(); exception = 1; exception_pc = 32'h400;
    step();
    chk("run after reset", {31'b0, trap_redirect}, 32'h1);
    idle();
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      csr_en          = ($urandom_range(0, 3) != 0);
      csr_op          = 2'($urandom_range(0, 3));
      csr_addr        = pool[$urandom_range(0, 15)];
      csr_wdata       = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      exception       = ($urandom_range(0, 15) == 0);
      mret            = ($urandom_range(0, 15) == 0);
      exception_pc    = $urandom;
      exception_cause = $urandom;
      interrupt       = 1'($urandom_range(0, 1));
      irq_ext         = 1'($urandom_range(0, 1));
      irq_timer       = 1'($urandom_range(0, 1));
      inst_retire     = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_csr_unit.md
# trap_csr_unit

Machine-mode trap CSR block, the consuming end of the exception unit's trap signalling. Latches trap state on an exception (mepc, mcause, mstatus stacking) and issues the registered redirect to mtvec. Handles mret and the Zicsr read/modify/write traffic from the memory stage. Generates level interrupt requests back toward the exception unit.

## Interface
Parameters:
- RESET_MTVEC, 32'h0000_8000, mtvec reset value (direct-mode handler address)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- exception  input  1  trap taken this cycle (from exception unit)
- exception_pc  input  32  PC of trapping instruction
- exception_cause  input  32  cause code; bit 31 ignored
- interrupt  input  1  trap is an interrupt (sets mcause[31])
- mret  input  1  mret in memory stage
- csr_en  input  1  CSR access valid
- csr_op  input  2  01 RW, 10 RS, 11 RC, 00 none
- csr_addr  input  12  CSR address
- csr_wdata  input  32  write / set / clear operand
- csr_rdata  output  32  old CSR value, combinational
- csr_illegal  output  1  access illegal, combinational
- irq_ext  input  1  external interrupt, level
- irq_timer  input  1  timer interrupt, level
- inst_retire  input  1  one instruction retired this cycle
- irq_req  output  1  enabled interrupt pending, registered
- irq_cause  output  32  cause for irq_req, registered
- trap_redirect  output  1  fetch redirect pulse, registered
- trap_target  output  32  redirect address, registered

## Operation
- CSRs: mstatus 0x300 (MIE b3, MPIE b7, MPP b12:11 hardwired 11, others 0); mie 0x304 (MTIE b7, MEIE b11, others 0); mtvec 0x305 (b1:0 read 0); mscratch 0x340; mepc 0x341 (b1:0 read 0); mcause 0x342; mtval 0x343; mip 0x344 read-only (MTIP = irq_timer, MEIP = irq_ext).
- Write value: RW → wdata; RS → old | wdata; RC → old & ~wdata. The write applies on the clock edge and is masked to the implemented bits.
- csr_illegal is asserted for an unimplemented address. It is also asserted for a write to a read-only address (addr[11:10]==11 or mip) when op==RW, or when op is RS/RC with wdata≠0. An illegal access performs no write; csr_rdata is 0.
- FSM states RUN, TRAP, RET.
  - RUN + exception → TRAP. On that edge: mepc←exception_pc; mcause←{interrupt, exception_cause[30:0]}; mtval←0; MPIE←MIE; MIE←0.
  - RUN + mret (no exception) → RET. On that edge: MIE←MPIE; MPIE←1.
  - TRAP/RET → RUN unconditionally after one cycle.
  - In TRAP/RET, exception, mret and CSR writes are ignored (the pipeline is flushed).
- Same-cycle priority in RUN: exception > mret > CSR write. A losing CSR write is dropped.
- irq_req is registered: (MEIP&MEIE | MTIP&MTIE) & MIE & state==RUN.
  - irq_cause is 0x8000_000B when the external interrupt qualifies (it has priority), else 0x8000_0007.

## Timing
- Reset values: mstatus 0x0000_1800, mie 0, mtvec RESET_MTVEC, mscratch/mepc/mcause/mtval 0, counters 0, state RUN, and all outputs 0.
- trap_redirect is a 1-cycle pulse in the cycle after exception/mret.
  - From TRAP: trap_target = mtvec with b1:0 = 0.
  - From RET: trap_target = mepc.
  - trap_target holds its last value otherwise.
- CSR reads are zero-latency. A write is visible to a read in the next cycle.
- Reset asserted mid-trap returns the block to RUN and drops the pending redirect.
- irq_req reflects input or enable changes one cycle later.

## Configuration
- ZICNTR_EN defined: the following counters are implemented.
  - mcycle 0xB00/0xB80 increments every cycle.
  - minstret 0xB02/0xB82 increments on inst_retire.
  - Both are 64-bit, wrap at 2^64, and are writable per 32-bit half.
  - Read-only shadows are at 0xC00/0xC80/0xC02/0xC82.
  - A write to a half suppresses the increment in that cycle; the carry into the other half is also suppressed.
- ZICNTR_EN undefined: no counters exist, and these addresses are illegal.

## Structure
- common_types_pkg holds the following, shared with the decoder and exception unit:
  - CSR address localparams
  - csr_op_t enum
  - trap_state_t enum {RUN, TRAP, RET}
  - cause constants (CAUSE_ILLEGAL=2, CAUSE_MTI=7, CAUSE_MEI=11)
- Sub-module csr_counter64: 64-bit counter with increment enable and lo/hi write strobes. It is instantiated twice under ZICNTR_EN.

## Test plan
- Reset → mtvec reads 0x8000, mstatus reads 0x1800, irq_req=0, trap_redirect=0.
- Set MIE, then exception with pc=0x124, cause=2 → the next cycle gives trap_redirect=1 and trap_target=0x8000. Afterwards mepc=0x124, mcause=2, MIE=0, MPIE=1.
- Issue mret after the trap → the next cycle gives trap_redirect=1 and trap_target=0x124. Afterwards MIE=1 and MPIE=1.
- Set mie=0x880 and MIE=1, then raise irq_timer and irq_ext together → irq_cause=0x8000_000B one cycle later. Drop irq_ext → irq_cause=0x8000_0007.
- Same cycle: CSR RW to mscratch with 0xAA, plus an exception → mscratch stays 0 and the trap is taken. CSRRW to 0xC00 → csr_illegal=1.
- With ZICNTR_EN: write mcycle lo with 0xFFFF_FFFF → two cycles later mcycleh=1. Without ZICNTR_EN: a read of 0xB00 gives csr_illegal=1.
